video_stream_capture: RTL and testbench
=======================================

VIDEO_STREAM_CAPTURE -- requirements
Module: video_stream_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 600, meaning active lines per frame.
REQ-003 SHALL have parameter SYNC_POL, default 1, meaning the asserted level of the sync inputs.
REQ-004 SHALL have parameter BUF_LOGDEPTH, default 2, meaning the output buffer holds 2^BUF_LOGDEPTH entries.
REQ-005 SHALL use one clock and a synchronous, active-high reset: pixel_clk (input, 1, sole clock) and rst (input, 1, synchronous active-high reset).
REQ-006 SHALL have ports:
- video_in_pData  input  24  pixel data
- video_in_pHSync  input  1  horizontal sync
- video_in_pVSync  input  1  vertical sync
- video_in_pVDE  input  1  data enable
- pixel_stream_dout  output  24  captured pixel
- pixel_stream_dout_sof  output  1  first pixel of frame
- pixel_stream_dout_eol  output  1  last pixel of line
- pixel_stream_dout_valid  output  1  output entry valid
- pixel_stream_dout_ready  input  1  consumer accepts
- locked  output  1  state is STREAM
- overflow  output  1  sticky, pixel dropped
- frame_err  output  1  sticky, geometry mismatch

Function
REQ-007 SHALL register all four video inputs in one input stage before any decision; HSync is registered but otherwise unused.
REQ-008 SHALL define a VSync edge as the registered VSync going from !SYNC_POL to SYNC_POL between consecutive cycles.
REQ-009 SHALL implement states SEEK, STREAM and DROP.
- SEEK: discard all pixels; go to STREAM on a VSync edge.
- STREAM: enqueue every registered pixel that has DE=1.
- DROP: discard all pixels; go to STREAM on a VSync edge.
REQ-010 SHALL go to DROP, discard the pixel and set overflow when a DE=1 pixel arrives in STREAM while the buffer is full.
REQ-011 SHALL treat the buffer as full based on its stored count only; a same-cycle dequeue SHALL NOT free space for that cycle's enqueue.
REQ-012 SHALL count with x over 0..H_ACTIVE-1 and y over lines, both clearing on every VSync edge.
- x increments on each enqueued pixel.
- At x==H_ACTIVE-1, x wraps to 0 and y increments.
REQ-013 SHALL store sof=1 with a pixel if and only if x==0 and y==0; it SHALL store eol=1 if and only if x==H_ACTIVE-1.
REQ-014 SHALL set frame_err in STREAM in either of these cases:
- registered DE falls while x!=0; x is then cleared to 0.
- a VSync edge occurs while y!=V_ACTIVE, except the first edge after SEEK or DROP.
REQ-015 SHALL give a latency of 2 cycles: a pixel presented in cycle N with the buffer empty appears with dout_valid=1 in cycle N+2.
REQ-016 SHALL follow ready/valid handshake rules:
- A transfer occurs when valid and ready are both 1 on a rising edge.
- dout, sof and eol SHALL hold stable while valid=1 and ready=0.
- valid SHALL NOT depend combinationally on ready.
REQ-017 SHALL deliver pixels in arrival order with no duplication.
REQ-018 SHALL wrap the buffer pointers modulo 2^BUF_LOGDEPTH.
REQ-019 SHALL keep entries already in the buffer after entering DROP and deliver them normally.
REQ-020 SHALL make overflow and frame_err sticky; only rst clears them.

Reset
REQ-021 SHALL on rst set the state to SEEK, empty the buffer and clear x, y and the input register.
REQ-022 SHALL on rst force dout_valid, sof, eol, locked, overflow and frame_err to 0, with dout=0.
REQ-023 SHALL take effect on the next edge when rst is asserted mid-frame or mid-handshake, discarding buffered data; capture SHALL restart at the next VSync edge.

Structure
REQ-024 SHALL take the timing constants (800x600 active, SYNC_POL) from the shared video-timing header also used by the display controller.
REQ-025 SHALL place the buffer in one sub-module, capture_buf: WIDTH=26 (data, sof, eol), LOGDEPTH parameter, full and empty outputs.

Verification (H_ACTIVE=4, V_ACTIVE=2, BUF_LOGDEPTH=2, SYNC_POL=1)
REQ-026 Pixels before the first VSync edge, then an edge, then 2 lines of 4 with data 1..8 and ready=1 -> output 1..8 in order; sof only on 1; eol on 4 and 8; locked=1; no error flags.
REQ-027 Same frame with ready=0 throughout -> 4 entries held stable; overflow=1 at pixel 5; state DROP; after ready=1 exactly 1..4 delivered; next VSync edge restores locked=1.
REQ-028 DE falls after 3 pixels of a line -> frame_err=1; the next line's first pixel is stored with x=0; overflow stays 0.
REQ-029 VSync edge after 1 complete line in STREAM -> frame_err=1; a following correct frame streams normally while frame_err stays 1.
REQ-030 rst pulsed with 3 entries buffered and ready toggling -> next cycle valid=0, flags 0, state SEEK; pixels ignored until the next VSync edge.
REQ-031 Single pixel into an empty buffer at cycle N -> valid=1 first seen at N+2; ready toggling every cycle still yields the exact input sequence.

Source files
------------

// File: rtl/video_stream_capture_pkg.sv
// Shared video-timing constants and capture-path types, used by the capture
// block and the display controller so that both agree on frame geometry.
package video_stream_capture_pkg;

    localparam int VT_H_ACTIVE = 800;
    localparam int VT_V_ACTIVE = 600;
    localparam int VT_SYNC_POL = 1;

    localparam int PIX_W   = 24;
    localparam int ENTRY_W = PIX_W + 2;

    typedef enum logic [1:0] {
        ST_SEEK,
        ST_STREAM,
        ST_DROP
    } cap_state_t;

    // One buffered pixel: data plus its frame/line markers.
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
    } pix_entry_t;

    // True when a sync line has just moved into its asserted level.
    function automatic logic sync_rise(input logic cur, input logic prev, input logic pol);
        return (cur == pol) && (prev != pol);
    endfunction

endpackage

// File: rtl/video_stream_capture_buf.sv
// capture_buf: first-word-fall-through FIFO; the head entry is visible on
// rd_data whenever empty is low, and fullness comes from the stored count.
module capture_buf #(
    parameter int WIDTH    = 26,
    parameter int LOGDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << LOGDEPTH;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [LOGDEPTH-1:0] wr_ptr;
    logic [LOGDEPTH-1:0] rd_ptr;
    logic [LOGDEPTH:0]   count;
    logic                do_wr;
    logic                do_rd;

    assign full    = (count == (LOGDEPTH + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_stream_capture.sv
// Captures active video into a ready/valid pixel stream, tagging frame and
// line boundaries and flagging overflow and frame-geometry errors.
module video_stream_capture
    import video_stream_capture_pkg::*;
#(
    parameter int H_ACTIVE     = VT_H_ACTIVE,
    parameter int V_ACTIVE     = VT_V_ACTIVE,
    parameter int SYNC_POL     = VT_SYNC_POL,
    parameter int BUF_LOGDEPTH = 2
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] video_in_pData,
    input  logic             video_in_pHSync,
    input  logic             video_in_pVSync,
    input  logic             video_in_pVDE,
    output logic [PIX_W-1:0] pixel_stream_dout,
    output logic             pixel_stream_dout_sof,
    output logic             pixel_stream_dout_eol,
    output logic             pixel_stream_dout_valid,
    input  logic             pixel_stream_dout_ready,
    output logic             locked,
    output logic             overflow,
    output logic             frame_err
);
    localparam int            XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int            YW     = $clog2(V_ACTIVE + 2);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_SAT  = YW'(V_ACTIVE + 1);
    localparam logic          POL    = (SYNC_POL != 0);

    logic [PIX_W-1:0] data_q;
    logic             hsync_unused_q;
    logic             vsync_q;
    logic             de_q;
    logic             vsync_p;
    logic             de_p;

    cap_state_t       state;
    cap_state_t       state_nx;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [XW-1:0]    x_base;
    logic [YW-1:0]    y_base;
    logic             vs_edge;
    logic             de_fall;
    logic             push;
    logic             ovf_set;
    logic             ferr_set;
    logic             overflow_q;
    logic             frame_err_q;

    pix_entry_t       wr_entry;
    pix_entry_t       rd_entry;
    logic             buf_full;
    logic             buf_empty;
    logic             out_valid;

    // Single input stage; decisions below only ever see registered video.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            data_q         <= '0;
            hsync_unused_q <= 1'b0;
            vsync_q        <= 1'b0;
            de_q           <= 1'b0;
            vsync_p        <= 1'b0;
            de_p           <= 1'b0;
        end else begin
            data_q         <= video_in_pData;
            hsync_unused_q <= video_in_pHSync;
            vsync_q        <= video_in_pVSync;
            de_q           <= video_in_pVDE;
            vsync_p        <= vsync_q;
            de_p           <= de_q;
        end
    end

    assign vs_edge = sync_rise(vsync_q, vsync_p, POL);
    assign de_fall = !de_q && de_p;

    always_ff @(posedge pixel_clk) begin
        if (rst) state <= ST_SEEK;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        ovf_set  = 1'b0;
        unique case (state)
            ST_SEEK, ST_DROP: begin
                if (vs_edge) state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                if (de_q) begin
                    if (buf_full) begin
                        state_nx = ST_DROP;
                        ovf_set  = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_nx = ST_SEEK;
        endcase
    end

    // Position of the pixel being considered this cycle: a VSync edge starts
    // a new frame, and a line cut short restarts the column count.
    always_comb begin
        x_base   = x;
        y_base   = y;
        ferr_set = 1'b0;
        if (state == ST_STREAM) begin
            if (vs_edge && (y != Y_END)) ferr_set = 1'b1;
            if (de_fall && (x != '0)) begin
                ferr_set = 1'b1;
                x_base   = '0;
            end
        end
        if (vs_edge) begin
            x_base = '0;
            y_base = '0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_base;
            y <= y_base;
            if (push) begin
                if (x_base == X_LAST) begin
                    x <= '0;
                    if (y_base != Y_SAT) y <= y_base + 1'b1;
                end else begin
                    x <= x_base + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | ovf_set;
            frame_err_q <= frame_err_q | ferr_set;
        end
    end

    assign wr_entry.data = data_q;
    assign wr_entry.sof  = (x_base == '0) && (y_base == '0);
    assign wr_entry.eol  = (x_base == X_LAST);

    capture_buf #(
        .WIDTH    (ENTRY_W),
        .LOGDEPTH (BUF_LOGDEPTH)
    ) u_buf (
        .clk     (pixel_clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (out_valid && pixel_stream_dout_ready),
        .rd_data (rd_entry),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // Outputs are forced to zero whenever nothing is being offered.
    assign out_valid               = !buf_empty;
    assign pixel_stream_dout_valid = out_valid;
    assign pixel_stream_dout       = out_valid ? rd_entry.data : '0;
    assign pixel_stream_dout_sof   = out_valid && rd_entry.sof;
    assign pixel_stream_dout_eol   = out_valid && rd_entry.eol;
    assign locked                  = (state == ST_STREAM);
    assign overflow                = overflow_q;
    assign frame_err               = frame_err_q;

endmodule

// File: tb/tb_video_stream_capture.sv
// Self-checking bench for video_stream_capture at a 4x2 geometry; a
// queue-based reference model predicts every output each cycle.
module tb_video_stream_capture;
    localparam int H     = 4;
    localparam int V     = 2;
    localparam int LOGD  = 2;
    localparam int DEPTH = 1 << LOGD;

    logic        pixel_clk = 1'b0;
    logic        rst       = 1'b1;
    logic [23:0] pdata     = '0;
    logic        hs        = 1'b0;
    logic        vs        = 1'b0;
    logic        de        = 1'b0;
    logic        ready     = 1'b0;

    logic [23:0] dout;
    logic        dout_sof;
    logic        dout_eol;
    logic        dout_valid;
    logic        locked;
    logic        overflow;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;  // 0 low, 1 high, 2 random, 3 toggle

    video_stream_capture #(
        .H_ACTIVE     (H),
        .V_ACTIVE     (V),
        .SYNC_POL     (1),
        .BUF_LOGDEPTH (LOGD)
    ) dut (
        .pixel_clk               (pixel_clk),
        .rst                     (rst),
        .video_in_pData          (pdata),
        .video_in_pHSync         (hs),
        .video_in_pVSync         (vs),
        .video_in_pVDE           (de),
        .pixel_stream_dout       (dout),
        .pixel_stream_dout_sof   (dout_sof),
        .pixel_stream_dout_eol   (dout_eol),
        .pixel_stream_dout_valid (dout_valid),
        .pixel_stream_dout_ready (ready),
        .locked                  (locked),
        .overflow                (overflow),
        .frame_err               (frame_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected stream contents and flags, derived from the
    // capture rules applied to what the input stage saw one cycle earlier.
    typedef struct {
        logic [23:0] d;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t        q[$];
    bit          streaming = 0;
    int          px = 0;
    int          ln = 0;
    bit          m_ovf = 0;
    bit          m_ferr = 0;
    logic [23:0] r_d = '0;
    logic        r_vs = 0, r_de = 0, p_vs = 0, p_de = 0;

    always @(posedge pixel_clk) begin : model
        int size0;
        bit edge_s, fall, was;
        if (rst) begin
            q.delete();
            streaming = 0; px = 0; ln = 0; m_ovf = 0; m_ferr = 0;
            r_d = '0; r_vs = 0; r_de = 0; p_vs = 0; p_de = 0;
        end else begin
            size0  = q.size();
            edge_s = r_vs && !p_vs;
            fall   = !r_de && p_de;
            was    = streaming;
            if (size0 > 0 && ready) void'(q.pop_front());
            if (was && edge_s && ln != V) m_ferr = 1;
            if (was && fall && px != 0) begin
                m_ferr = 1;
                px = 0;
            end
            if (edge_s) begin
                px = 0;
                ln = 0;
            end
            if (was && r_de) begin
                if (size0 == DEPTH) begin
                    m_ovf = 1;
                    streaming = 0;
                end else begin
                    q.push_back('{d: r_d, sof: (px == 0 && ln == 0), eol: (px == H - 1)});
                    px++;
                    if (px == H) begin
                        px = 0;
                        ln++;
                    end
                end
            end
            if (!was && edge_s) streaming = 1;
            p_vs = r_vs; p_de = r_de;
            r_vs = vs;   r_de = de;   r_d = pdata;
        end
    end

    always @(negedge pixel_clk) begin
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            2:       ready = ($urandom_range(0, 3) != 0);
            default: ready = ~ready;
        endcase
    end

    // Cycle-by-cycle scoreboard against the model.
    always @(negedge pixel_clk) begin
        check("valid", 32'(dout_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("dout", 32'(dout), 32'(q[0].d));
            check("sof", 32'(dout_sof), 32'(q[0].sof));
            check("eol", 32'(dout_eol), 32'(q[0].eol));
        end
        check("locked", 32'(locked), 32'(streaming));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
    end

    task automatic step(input logic v, input logic e, input logic [23:0] d);
        vs = v; de = e; pdata = d;
        hs = 1'($urandom_range(0, 1));
        @(negedge pixel_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 24'h0);
    endtask

    task automatic vsync_edge();
        step(1'b1, 1'b0, 24'h0);
        step(1'b1, 1'b0, 24'h0);
        idle(3);
    endtask

    task automatic line(input int len, input logic [23:0] base);
        for (int i = 0; i < len; i++) step(1'b0, 1'b1, base + 24'(i));
        idle(2);
    endtask

    task automatic frame(input int nl, input int len, input logic [23:0] base);
        for (int l = 0; l < nl; l++) line(len, base + 24'(l * len));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge pixel_clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ready_mode = 1;
        while ((q.size() != 0 || dout_valid) && n < 64) begin
            @(negedge pixel_clk);
            n++;
        end
        check("drain_timeout", 32'(n < 64), 32'd1);
        check("drain_empty", 32'(dout_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge pixel_clk);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst = 1'b0;

        // Pixels before any edge are ignored; then one clean 4x2 frame.
        ready_mode = 1;
        line(4, 24'h50);
        check("seek_locked", 32'(locked), 32'd0);
        vsync_edge();
        frame(2, 4, 24'h1);
        drain();
        check("f1_locked", 32'(locked), 32'd1);
        check("f1_ferr", 32'(frame_err), 32'd0);
        check("f1_ovf", 32'(overflow), 32'd0);

        // Consumer stalled for a whole frame: four entries held, then overflow.
        ready_mode = 0;
        vsync_edge();
        frame(2, 4, 24'h1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop", 32'(locked), 32'd0);
        check("ovf_hold", 32'(dout), 32'd1);
        drain();
        vsync_edge();
        check("ovf_relock", 32'(locked), 32'd1);

        // Line cut short after 3 pixels.
        pulse_rst();
        vsync_edge();
        line(3, 24'h30);
        line(4, 24'h40);
        drain();
        check("short_ferr", 32'(frame_err), 32'd1);
        check("short_ovf", 32'(overflow), 32'd0);

        // Frame of a single line, then a correct frame.
        pulse_rst();
        vsync_edge();
        line(4, 24'h20);
        vsync_edge();
        check("vshort_ferr", 32'(frame_err), 32'd1);
        frame(2, 4, 24'h60);
        vsync_edge();
        drain();
        check("vshort_locked", 32'(locked), 32'd1);
        check("vshort_sticky", 32'(frame_err), 32'd1);

        // Reset with three entries buffered and ready toggling.
        ready_mode = 0;
        line(3, 24'h70);
        ready_mode = 3;
        idle(2);
        pulse_rst();
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        ready_mode = 1;
        line(4, 24'h80);
        idle(3);
        check("mid_rst_ignore", 32'(dout_valid), 32'd0);

        // Latency of a lone pixel, then a frame under toggling ready.
        vsync_edge();
        idle(2);
        check("lat_n0", 32'(dout_valid), 32'd0);
        step(1'b0, 1'b1, 24'hAB);
        check("lat_n1", 32'(dout_valid), 32'd0);
        idle(1);
        check("lat_n2", 32'(dout_valid), 32'd1);
        check("lat_data", 32'(dout), 32'h0000_00AB);
        ready_mode = 3;
        idle(3);
        frame(2, 4, 24'h90);
        vsync_edge();
        drain();

        // Randomized frames, mostly well-formed, with random back-pressure.
        pulse_rst();
        for (int f = 0; f < 12; f++) begin
            int nl, len;
            bit ok;
            ready_mode = 2;
            ok = ($urandom_range(0, 3) != 0);
            nl = ok ? V : int'($urandom_range(1, 3));
            vsync_edge();
            for (int l = 0; l < nl; l++) begin
                len = ok ? H : int'($urandom_range(1, 5));
                for (int i = 0; i < len; i++) step(1'b0, 1'b1, 24'($urandom));
                idle(int'($urandom_range(1, 3)));
            end
            if (f == 6) pulse_rst();
        end
        vsync_edge();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
